// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: MMIO address map, funct3
// encodings, and helpers for access legality, byte enables and load extension.
package mem_pkg;

    localparam logic [31:0] LEDS_ADDR   = 32'hFFFF_FFFC;
    localparam logic [31:0] MILLIS_ADDR = 32'hFFFF_FFF8;
    localparam logic [31:0] MICROS_ADDR = 32'hFFFF_FFF4;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_f3_e;

    function automatic logic load_legal(input logic [2:0] f3);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    function automatic logic store_legal(input logic [2:0] f3);
        return (f3 == SB) || (f3 == SH) || (f3 == SW);
    endfunction

    // funct3[1:0] encodes the size for both loads and stores.
    function automatic logic aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return ~off[0];
            2'b10:   return off == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        case (store_f3_e'(f3))
            SB:      return 4'b0001 << off;
            SH:      return off[1] ? 4'b1100 : 4'b0011;
            SW:      return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the store data into every lane so the byte enables alone pick the target.
    function automatic logic [31:0] store_lanes(input logic [31:0] data, input logic [2:0] f3);
        case (store_f3_e'(f3))
            SB:      return {4{data[7:0]}};
            SH:      return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (load_f3_e'(f3))
            LB:      return {{24{b[7]}}, b};
            LH:      return {{16{h[15]}}, h};
            LW:      return word;
            LBU:     return {24'd0, b};
            LHU:     return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running microsecond and millisecond counters derived from clk.
module mmio_timer #(
    parameter int unsigned CLK_FREQ_HZ = 12000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] micros,
    output logic [31:0] millis
);

    // Clocks slower than 1 MHz fall back to one MICROS tick per cycle.
    localparam int unsigned DIV     = (CLK_FREQ_HZ >= 1000000) ? CLK_FREQ_HZ / 1000000 : 1;
    localparam logic [31:0] PRE_MAX = 32'(DIV - 1);

    logic [31:0] prescaler;
    logic [9:0]  sub_ms;

    // Prescaler wrap advances MICROS; every 1000th MICROS tick advances MILLIS.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            sub_ms    <= '0;
            micros    <= '0;
            millis    <= '0;
        end else if (prescaler == PRE_MAX) begin
            prescaler <= '0;
            micros    <= micros + 32'd1;
            if (sub_ms == 10'd999) begin
                sub_ms <= '0;
                millis <= millis + 32'd1;
            end else begin
                sub_ms <= sub_ms + 10'd1;
            end
        end else begin
            prescaler <= prescaler + 32'd1;
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Target side of the processor memory bus: unified RAM plus an MMIO window
// holding the LED register and the MICROS/MILLIS timers.
module memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter              INIT_FILE   = "",
    parameter int unsigned CLK_FREQ_HZ = 12000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_en,
    input  logic [31:0] memory_read_address,
    input  logic        write_en,
    input  logic [31:0] memory_write_address,
    input  logic [31:0] memory_write,
    input  logic [2:0]  funct3,
    output logic [31:0] memory_read_value,
    output logic        read_valid,
    output logic        access_error,
    output logic [7:0]  leds
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] micros;
    logic [31:0] millis;

    mmio_timer #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .micros (micros),
        .millis (millis)
    );

    logic [1:0]    rd_off;
    logic [AW-1:0] rd_idx;
    logic          rd_ok;
    logic [31:0]   rd_word;
    logic [1:0]    wr_off;
    logic [AW-1:0] wr_idx;
    logic          wr_ok;
    logic          wr_ram;
    logic          wr_leds;
    logic [3:0]    wr_be;
    logic [31:0]   wr_lanes;

    assign rd_off = memory_read_address[1:0];
    assign rd_idx = memory_read_address[AW+1:2];
    assign wr_off = memory_write_address[1:0];
    assign wr_idx = memory_write_address[AW+1:2];

    // Decode both ports: region hit, legality, and the raw word a read would see.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        rd_ok    = 1'b0;
        rd_word  = 32'd0;
        wr_ok    = 1'b0;
        wr_ram   = 1'b0;
        wr_leds  = 1'b0;
        wr_be    = byte_enable(funct3, wr_off);
        wr_lanes = store_lanes(memory_write, funct3);

        if (load_legal(funct3) && aligned(funct3, rd_off)) begin
            if (memory_read_address < RAM_BYTES) begin
                rd_ok   = 1'b1;
                rd_word = mem[rd_idx];
            end else if (memory_read_address[31:2] == LEDS_ADDR[31:2]) begin
                rd_ok   = 1'b1;
                rd_word = {24'd0, leds};
            end else if (memory_read_address[31:2] == MILLIS_ADDR[31:2]) begin
                rd_ok   = 1'b1;
                rd_word = millis;
            end else if (memory_read_address[31:2] == MICROS_ADDR[31:2]) begin
                rd_ok   = 1'b1;
                rd_word = micros;
            end
        end

        // Timer addresses are legal write targets; the data is simply discarded.
        if (store_legal(funct3) && aligned(funct3, wr_off)) begin
            wr_ram  = memory_write_address < RAM_BYTES;
            wr_leds = memory_write_address[31:2] == LEDS_ADDR[31:2];
            wr_ok   = wr_ram || wr_leds
                   || (memory_write_address[31:2] == MILLIS_ADDR[31:2])
                   || (memory_write_address[31:2] == MICROS_ADDR[31:2]);
        end
    end

    // Registered read response, error flag and LED register.
    always_ff @(posedge clk) begin
        if (reset) begin
            memory_read_value <= 32'd0;
            read_valid        <= 1'b0;
            access_error      <= 1'b0;
            leds              <= 8'd0;
        end else begin
            read_valid        <= read_en;
            memory_read_value <= (read_en && rd_ok) ? load_extend(rd_word, funct3, rd_off) : 32'd0;
            access_error      <= (read_en && !rd_ok) || (write_en && !wr_ok);
            if (write_en && wr_ok && wr_leds && wr_be[0]) begin
                leds <= wr_lanes[7:0];
            end
        end
    end

    // RAM byte-lane writes; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        // NOTE: RAM contents are deliberately left out of reset so it maps onto block RAM;
        // the non-blocking update also gives a same-cycle read the pre-write word.
        if (!reset && write_en && wr_ok && wr_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them when they fall due.
module tb_memory_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic [31:0] ra = '0;
    logic [31:0] wa = '0;
    logic [31:0] wd = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] memory_read_value;
    logic        read_valid;
    logic        access_error;
    logic [7:0]  leds;

    memory_responder #(
        .DEPTH_WORDS (2048),
        .INIT_FILE   (""),
        .CLK_FREQ_HZ (4000000)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .read_en              (read_en),
        .memory_read_address  (ra),
        .write_en             (write_en),
        .memory_write_address (wa),
        .memory_write         (wd),
        .funct3               (f3),
        .memory_read_value    (memory_read_value),
        .read_valid           (read_valid),
        .access_error         (access_error),
        .leds                 (leds)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic        is_read;
        logic [31:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every response is due exactly one cycle after its request.
    always @(negedge clk) begin
        if (!reset) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                check({mon_e.name, ".valid"}, {31'd0, read_valid}, {31'd0, mon_e.is_read});
                if (mon_e.is_read) check({mon_e.name, ".data"}, memory_read_value, mon_e.data);
                check({mon_e.name, ".err"}, {31'd0, access_error}, {31'd0, mon_e.err});
            end else if (read_valid || access_error) begin
                check("unexpected_response", {30'd0, read_valid, access_error}, 32'd0);
            end
        end
    end

    // Drive one request for one cycle; called and returns at a negedge.
    task automatic issue(input logic rd, input logic [31:0] raddr, input logic wr,
                         input logic [31:0] waddr, input logic [31:0] wdata, input logic [2:0] fn,
                         input logic [31:0] exp_data, input logic exp_err, input string name);
        read_en  = rd;
        ra       = raddr;
        write_en = wr;
        wa       = waddr;
        wd       = wdata;
        f3       = fn;
        if (rd || exp_err) sb.push_back('{cyc + 1, rd, exp_data, exp_err, name});
        @(negedge clk);
        read_en  = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [2:0] fn, input logic [31:0] exp_data,
                      input logic exp_err, input string name);
        issue(1'b1, addr, 1'b0, 32'd0, 32'd0, fn, exp_data, exp_err, name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] fn,
                      input logic exp_err, input string name);
        issue(1'b0, 32'd0, 1'b1, addr, data, fn, 32'd0, exp_err, name);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        check({name, ".drain"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();
        check("rst.read_valid", {31'd0, read_valid}, 32'd0);
        check("rst.access_error", {31'd0, access_error}, 32'd0);
        check("rst.leds", {24'd0, leds}, 32'd0);
        check("rst.read_value", memory_read_value, 32'd0);

        // Word write and read-back
        wr(32'h10, 32'hDEADBEEF, SW, 1'b0, "sw1");
        rd(32'h10, LW, 32'hDEADBEEF, 1'b0, "lw1");

        // Byte store over the word, signed/unsigned loads
        wr(32'h13, 32'h00000080, SB, 1'b0, "sb1");
        rd(32'h13, LB,  32'hFFFFFF80, 1'b0, "lb13");
        rd(32'h13, LBU, 32'h00000080, 1'b0, "lbu13");
        rd(32'h10, LW,  32'h80ADBEEF, 1'b0, "lw_after_sb");

        // Misaligned and illegal-width accesses
        wr(32'h11, 32'h00001234, SH, 1'b1, "sh_mis");
        wr(32'h12, 32'hFFFFFFFF, SW, 1'b1, "sw_mis");
        wr(32'h10, 32'h00000000, 3'b011, 1'b1, "st_bad_f3");
        rd(32'h11, LW, 32'h0, 1'b1, "lw_mis");
        rd(32'h13, LH, 32'h0, 1'b1, "lh_mis");
        rd(32'h10, 3'b011, 32'h0, 1'b1, "ld_bad_f3_3");
        rd(32'h10, 3'b110, 32'h0, 1'b1, "ld_bad_f3_6");
        rd(32'h10, LW, 32'h80ADBEEF, 1'b0, "lw_unchanged");

        // RAM upper boundary and out-of-range
        wr(32'h1FFC, 32'h0BADF00D, SW, 1'b0, "sw_top");
        rd(32'h1FFC, LW, 32'h0BADF00D, 1'b0, "lw_top");
        wr(32'h2000, 32'h00000001, SW, 1'b1, "sw_oor");
        rd(32'h2000, LW, 32'h0, 1'b1, "lw_oor");
        rd(32'hFFFFFFF0, LW, 32'h0, 1'b1, "lw_hole");

        // Legal halfword accesses
        wr(32'h12, 32'h0000CAFE, SH, 1'b0, "sh12");
        rd(32'h12, LH,  32'hFFFFCAFE, 1'b0, "lh12");
        rd(32'h12, LHU, 32'h0000CAFE, 1'b0, "lhu12");
        rd(32'h10, LH,  32'hFFFFBEEF, 1'b0, "lh10");
        rd(32'h11, LB,  32'hFFFFFFBE, 1'b0, "lb11");

        // Same-cycle read and write: read sees the old word
        wr(32'h20, 32'h11111111, SW, 1'b0, "sw20");
        issue(1'b1, 32'h20, 1'b1, 32'h20, 32'h22222222, SW, 32'h11111111, 1'b0, "rbw");
        rd(32'h20, LW, 32'h22222222, 1'b0, "lw20_new");

        // LED register and read-only timer addresses
        wr(LEDS_ADDR, 32'h000000A5, SW, 1'b0, "sw_leds");
        check("leds_a5", {24'd0, leds}, 32'h000000A5);
        rd(LEDS_ADDR, LW, 32'h000000A5, 1'b0, "lw_leds");
        rd(LEDS_ADDR, LB, 32'hFFFFFFA5, 1'b0, "lb_leds");
        rd(32'hFFFFFFFD, LBU, 32'h0, 1'b0, "lbu_leds1");
        wr(32'hFFFFFFFD, 32'h0000003C, SB, 1'b0, "sb_leds1");
        check("leds_lane1", {24'd0, leds}, 32'h000000A5);
        wr(LEDS_ADDR, 32'h0000005A, SB, 1'b0, "sb_leds0");
        check("leds_5a", {24'd0, leds}, 32'h0000005A);
        wr(MILLIS_ADDR, 32'h0000FFFF, SW, 1'b0, "sw_millis");
        wr(MICROS_ADDR, 32'h0000FFFF, SW, 1'b0, "sw_micros");
        drain("t5");

        // Timers: 4 cycles per microsecond, read issued W cycles after reset returns floor(W/4)
        do_reset();
        check("leds_after_reset", {24'd0, leds}, 32'd0);
        repeat (3998) @(negedge clk);
        rd(MILLIS_ADDR, LW, 32'd0,    1'b0, "millis_3998");
        rd(MICROS_ADDR, LW, 32'd999,  1'b0, "micros_3999");
        rd(MICROS_ADDR, LW, 32'd1000, 1'b0, "micros_4000");
        rd(MILLIS_ADDR, LW, 32'd1,    1'b0, "millis_4001");
        drain("timers");

        // Reset arriving with a write in flight
        wr(32'h30, 32'h12345678, SW, 1'b0, "sw30");
        wr(LEDS_ADDR, 32'h00000077, SB, 1'b0, "sb_leds77");
        check("leds_77", {24'd0, leds}, 32'h00000077);
        drain("pre_reset");
        reset    = 1'b1;
        read_en  = 1'b1;
        ra       = 32'h30;
        write_en = 1'b1;
        wa       = 32'h30;
        wd       = 32'h99999999;
        f3       = SW;
        @(negedge clk);
        read_en  = 1'b0;
        write_en = 1'b0;
        check("midrst.read_valid", {31'd0, read_valid}, 32'd0);
        check("midrst.access_error", {31'd0, access_error}, 32'd0);
        check("midrst.read_value", memory_read_value, 32'd0);
        check("midrst.leds", {24'd0, leds}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd(MICROS_ADDR, LW, 32'd0, 1'b0, "micros_restart");
        rd(32'h30, LW, 32'h12345678, 1'b0, "lw30_kept");
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
